// File: rtl/cursor_pkg.sv
// Cursor overlay controller shared types.
// Mode values, FSM encoding and default screen limits.
package cursor_pkg;

  localparam logic MODE_MOUSE = 1'b0;
  localparam logic MODE_SCOPE = 1'b1;

  typedef enum logic [1:0] {
    ST_MOUSE  = 2'd0,
    ST_SCOPE  = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  localparam int unsigned X_MAX_DEF      = 799;
  localparam int unsigned Y_MAX_DEF      = 599;
  localparam int unsigned SCOPE_XLIM_DEF = 600;
  localparam int unsigned COOLDOWN_DEF   = 30;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } pos_t;

  function automatic logic [11:0] clamp12(
    input logic [11:0] v,
    input logic [11:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/cursor_frame_ctl_rise_det.sv
// Rising-edge detector with cleared history.
// The first sample after reset only primes the history.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic hist;
  logic armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      hist  <= d;
      armed <= 1'b1;
    end
  end

  // A level already high when reset drops is not an edge.
  assign pulse = armed & d & ~hist;

endmodule

// File: rtl/cursor_frame_ctl.sv
// Frame-synchronous cursor controller.
// Latches clamped position per frame, runs mode FSM and fire cooldown.
module cursor_frame_ctl
  import cursor_pkg::*;
#(
  parameter int unsigned X_MAX       = X_MAX_DEF,
  parameter int unsigned Y_MAX       = Y_MAX_DEF,
  parameter int unsigned SCOPE_XLIM  = SCOPE_XLIM_DEF,
  parameter int unsigned COOLDOWN_FR = COOLDOWN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        left_btn,
  input  logic        select_req,
  input  logic        vblnk,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        mode_out,
  output logic        fire_pulse,
  output logic        fire_ready,
  output logic [7:0]  cooldown
);

  localparam logic [11:0] XM   = 12'(X_MAX);
  localparam logic [11:0] YM   = 12'(Y_MAX);
  localparam logic [11:0] XLIM = 12'(SCOPE_XLIM);
  localparam logic [7:0]  CD0  = 8'(COOLDOWN_FR);

  logic   frame_tick;
  logic   click;
  logic   scope_ok;
  state_t state;
  state_t state_n;
  logic [7:0] cd_n;
  logic   fire_n;
  pos_t   pos;

  rise_det u_vblnk_det (
    .clk   (clk),
    .rst   (rst),
    .d     (vblnk),
    .pulse (frame_tick)
  );

  rise_det u_btn_det (
    .clk   (clk),
    .rst   (rst),
    .d     (left_btn),
    .pulse (click)
  );

  assign scope_ok = select_req & (xpos_in < XLIM);

  always_comb begin
    state_n = state;
    cd_n    = cooldown;
    fire_n  = 1'b0;
    unique case (state)
      ST_MOUSE: begin
        if (frame_tick && scope_ok)
          state_n = ST_SCOPE;
      end
      ST_SCOPE: begin
        // A shot outranks a same-cycle frame exit.
        if (click) begin
          state_n = ST_RELOAD;
          fire_n  = 1'b1;
          cd_n    = CD0;
        end else if (frame_tick && !scope_ok) begin
          state_n = ST_MOUSE;
        end
      end
      ST_RELOAD: begin
        if (frame_tick) begin
          cd_n = cooldown - 8'd1;
          if (cooldown == 8'd1)
            state_n = scope_ok ? ST_SCOPE : ST_MOUSE;
        end
      end
      default: begin
        state_n = ST_MOUSE;
        cd_n    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_MOUSE;
      cooldown   <= 8'd0;
      fire_pulse <= 1'b0;
      pos        <= '0;
    end else begin
      state      <= state_n;
      cooldown   <= cd_n;
      fire_pulse <= fire_n;
      if (frame_tick) begin
        pos.x <= clamp12(xpos_in, XM);
        pos.y <= clamp12(ypos_in, YM);
      end
    end
  end

  assign xpos_out   = pos.x;
  assign ypos_out   = pos.y;
  assign mode_out   = (state == ST_MOUSE) ? MODE_MOUSE
                                          : MODE_SCOPE;
  assign fire_ready = (state == ST_SCOPE);

endmodule

// File: tb/tb_cursor_frame_ctl.sv
// Bench for cursor_frame_ctl: directed scenarios
// plus random traffic against a behavioural model.
module tb_cursor_frame_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_in = '0;
  logic [11:0] ypos_in = '0;
  logic        left_btn = 1'b0;
  logic        select_req = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] xpos_out;
  logic [11:0] ypos_out;
  logic        mode_out;
  logic        fire_pulse;
  logic        fire_ready;
  logic [7:0]  cooldown;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  cursor_frame_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .left_btn   (left_btn),
    .select_req (select_req),
    .vblnk      (vblnk),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out),
    .mode_out   (mode_out),
    .fire_pulse (fire_pulse),
    .fire_ready (fire_ready),
    .cooldown   (cooldown)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int mx, my;
  bit in_scope;
  int reload_left;
  bit m_pulse;
  bit prev_v, prev_b, hist_ok;

  always @(posedge clk) begin
    bit tick, clk_ev, ok;
    if (rst) begin
      mx = 0; my = 0; in_scope = 0;
      reload_left = 0; m_pulse = 0;
      prev_v = 0; prev_b = 0; hist_ok = 0;
    end else begin
      tick   = hist_ok && vblnk && !prev_v;
      clk_ev = hist_ok && left_btn && !prev_b;
      ok = select_req && (int'(xpos_in) < 600);
      m_pulse = 0;
      if (tick) begin
        mx = (int'(xpos_in) > 799) ? 799 : int'(xpos_in);
        my = (int'(ypos_in) > 599) ? 599 : int'(ypos_in);
      end
      if (reload_left > 0) begin
        if (tick) begin
          reload_left--;
          if (reload_left == 0) in_scope = ok;
        end
      end else if (in_scope) begin
        if (clk_ev) begin
          reload_left = 30;
          m_pulse = 1;
        end else if (tick && !ok) begin
          in_scope = 0;
        end
      end else if (tick && ok) begin
        in_scope = 1;
      end
      prev_v = vblnk; prev_b = left_btn; hist_ok = 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_mode, e_rdy;
      e_mode = in_scope || (reload_left > 0);
      e_rdy  = in_scope && (reload_left == 0);
      n_chk++;
      if (int'(xpos_out) != mx || int'(ypos_out) != my ||
          mode_out !== e_mode || fire_pulse !== m_pulse ||
          fire_ready !== e_rdy ||
          int'(cooldown) != reload_left) begin
        n_fail++;
        $display("FAIL model t=%0t got x=%0d y=%0d m=%0b p=%0b r=%0b cd=%0d want x=%0d y=%0d m=%0b p=%0b r=%0b cd=%0d",
          $time, xpos_out, ypos_out, mode_out, fire_pulse,
          fire_ready, cooldown, mx, my, e_mode, m_pulse,
          e_rdy, reload_left);
      end
    end
  end

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic frame();
    vblnk = 1'b0;
    step(1);
    vblnk = 1'b1;
    step(1);
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
  end

  initial begin
    // 1 reset with levels high
    rst = 1'b1; vblnk = 1'b1; left_btn = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    check("rst_x", int'(xpos_out), 0);
    check("rst_mode", int'(mode_out), 0);
    check("rst_pulse", int'(fire_pulse), 0);
    check("rst_ready", int'(fire_ready), 0);
    check("rst_cd", int'(cooldown), 0);
    vblnk = 1'b0; left_btn = 1'b0;
    step(1);

    // 2 clamp
    xpos_in = 12'd900; ypos_in = 12'd700;
    frame();
    check("clamp_x", int'(xpos_out), 799);
    check("clamp_y", int'(ypos_out), 599);
    xpos_in = 12'd10; ypos_in = 12'd10;
    step(3);
    check("hold_x", int'(xpos_out), 799);
    frame();
    check("next_x", int'(xpos_out), 10);
    check("next_y", int'(ypos_out), 10);

    // 3 mode
    select_req = 1'b1; xpos_in = 12'd300;
    frame();
    check("scope_mode", int'(mode_out), 1);
    check("scope_ready", int'(fire_ready), 1);
    xpos_in = 12'd650;
    frame();
    check("exit_mode", int'(mode_out), 0);
    xpos_in = 12'd300;
    frame();
    check("reenter_mode", int'(mode_out), 1);

    // 4 fire and reload
    left_btn = 1'b1;
    step(1);
    check("fire_pulse", int'(fire_pulse), 1);
    check("fire_cd", int'(cooldown), 30);
    check("fire_ready0", int'(fire_ready), 0);
    step(1);
    check("pulse_once", int'(fire_pulse), 0);
    left_btn = 1'b0;
    for (int f = 0; f < 29; f++) begin
      left_btn = 1'b1; step(1);
      left_btn = 1'b0;
      frame();
    end
    check("cd_last", int'(cooldown), 1);
    frame();
    check("cd_done", int'(cooldown), 0);
    check("back_mode", int'(mode_out), 1);
    check("back_ready", int'(fire_ready), 1);

    // 5 collision
    vblnk = 1'b0; step(1);
    xpos_in = 12'd123; ypos_in = 12'd45;
    vblnk = 1'b1; left_btn = 1'b1;
    step(1);
    check("coll_pulse", int'(fire_pulse), 1);
    check("coll_cd", int'(cooldown), 30);
    check("coll_x", int'(xpos_out), 123);
    left_btn = 1'b0;

    // 6 reset mid-reload
    for (int f = 0; f < 18; f++) frame();
    check("cd12", int'(cooldown), 12);
    rst = 1'b1;
    step(1);
    check("rst_cd0", int'(cooldown), 0);
    check("rst_mode0", int'(mode_out), 0);
    check("rst_rdy0", int'(fire_ready), 0);
    rst = 1'b0;
    step(2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      vblnk      = ($urandom_range(0, 3) == 0);
      left_btn   = ($urandom_range(0, 5) == 0);
      select_req = ($urandom_range(0, 7) != 0);
      xpos_in    = ($urandom_range(0, 3) == 0)
                   ? 12'($urandom_range(0, 4095))
                   : 12'($urandom_range(0, 700));
      ypos_in    = 12'($urandom_range(0, 4095));
      rst        = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
